// File: rtl/soc_pmem_arb_pkg.sv
// Shared types and helpers for the two-requester program-memory arbiter.
`ifndef PMEM_MSB
`define PMEM_MSB 9
`endif

package soc_pmem_arb_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/soc_rr_arb2.sv
// Combinational 2-way round-robin select with lock override.
module soc_rr_arb2
    import soc_pmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_e       last_gnt_i,
    input  logic       lock_vld_i,
    input  req_e       lock_own_i,
    output logic       gnt_vld_o,
    output req_e       winner_o
);

    // req_i[0] is requester A, req_i[1] is requester B
    always_comb begin
        gnt_vld_o = |req_i;
        winner_o  = REQ_A;
        if (req_i == 2'b11) begin
            if (lock_vld_i) begin
                winner_o = lock_own_i;
            end else begin
                winner_o = (last_gnt_i == REQ_A) ? REQ_B : REQ_A;
            end
        end else if (req_i[1]) begin
            winner_o = REQ_B;
        end
    end

endmodule

// File: rtl/soc_pmem_arb.sv
// Two-requester arbiter in front of one program-memory RAM port, with
// locked bursts capped at MAX_BURST and one-cycle read-valid tracking.
`ifndef PMEM_MSB
`define PMEM_MSB 9
`endif

module soc_pmem_arb
    import soc_pmem_arb_pkg::*;
#(
    parameter int ADDR_MSB  = `PMEM_MSB,
    parameter int MAX_BURST = 8
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              a_req,
    input  logic              a_lock,
    input  logic [1:0]        a_we,
    input  logic [ADDR_MSB:0] a_addr,
    input  logic [15:0]       a_din,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [15:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_lock,
    input  logic [1:0]        b_we,
    input  logic [ADDR_MSB:0] b_addr,
    input  logic [15:0]       b_din,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [15:0]       b_rdata,
    output logic              ram_en,
    output logic [1:0]        ram_we,
    output logic [ADDR_MSB:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    localparam int            CW      = burst_cnt_w(MAX_BURST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    req_e          last_gnt_q, last_gnt_d;
    logic          lock_q, lock_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_rvalid_q, b_rvalid_q;

    logic gnt_vld;
    req_e winner;
    logic lock_vld;
    logic win_lock;

    // An expired burst drops back to round-robin, which hands over to the other side
    assign lock_vld = lock_q && (cnt_q != CNT_MAX);

    soc_rr_arb2 u_rr_arb2 (
        .req_i      ({b_req, a_req}),
        .last_gnt_i (last_gnt_q),
        .lock_vld_i (lock_vld),
        .lock_own_i (last_gnt_q),
        .gnt_vld_o  (gnt_vld),
        .winner_o   (winner)
    );

    assign a_gnt = ~puc_rst & gnt_vld & (winner == REQ_A);
    assign b_gnt = ~puc_rst & gnt_vld & (winner == REQ_B);

    always_comb begin
        ram_en   = a_gnt | b_gnt;
        ram_we   = 2'b00;
        ram_addr = '0;
        ram_din  = '0;
        win_lock = 1'b0;
        if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_din;
            win_lock = a_lock;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_din;
            win_lock = b_lock;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_d     = 1'b0;
        cnt_d      = '0;
        if (ram_en) begin
            last_gnt_d = winner;
            if (win_lock) begin
                lock_d = 1'b1;
                if (lock_q && (last_gnt_q == winner)) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    cnt_d = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            last_gnt_q <= REQ_B;
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_gnt & (a_we == 2'b00);
            b_rvalid_q <= b_gnt & (b_we == 2'b00);
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule
